// File: rtl/channel_model.sv
// Channel model: feed-forward ISI taps plus a single feedback pole, Q-format fixed point.
// Optional LFSR noise injection is enabled by defining CHANNEL_NOISE_EN.
module channel_model #(
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int FRAC       = 14,
  parameter int NUM_TAPS   = 4,
  parameter int NOISE_BITS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  input  logic signed [DATA_W-1:0]             in_data,
  input  logic                                 coef_wr,
  input  logic        [$clog2(NUM_TAPS+1)-1:0] coef_addr,
  input  logic signed [COEF_W-1:0]             coef_wdata,
  output logic                                 out_valid,
  output logic signed [DATA_W-1:0]             out_data
);

  localparam int ADDR_W = $clog2(NUM_TAPS + 1);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + ADDR_W;

  localparam int C0_RST = $rtoi(0.2696 * (2.0 ** FRAC) + 0.5);
  localparam int A_RST  = $rtoi(0.7304 * (2.0 ** FRAC) + 0.5);

  localparam logic signed [COEF_W-1:0] C0_INIT = COEF_W'(C0_RST);
  localparam logic signed [COEF_W-1:0] A_INIT  = COEF_W'(A_RST);

  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  if (NUM_TAPS < 1) begin : g_bad_taps
    $error("channel_model: NUM_TAPS must be at least 1");
  end
  if (NOISE_BITS < 1 || NOISE_BITS > 16) begin : g_bad_noise
    $error("channel_model: NOISE_BITS must be in 1..16");
  end

  logic signed [DATA_W-1:0] r_dly  [NUM_TAPS];
  logic signed [COEF_W-1:0] r_coef [NUM_TAPS];
  logic signed [COEF_W-1:0] r_pole;
  logic signed [DATA_W-1:0] r_y;
  logic signed [DATA_W-1:0] r_out_data;
  logic                     r_out_valid;

  logic signed [PROD_W-1:0] w_prod [NUM_TAPS+1];
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [ACC_W-1:0]  w_rnd;
  logic signed [ACC_W-1:0]  w_shf;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_noise;
  logic signed [DATA_W-1:0] w_sat;

`ifdef CHANNEL_NOISE_EN
  logic [15:0] r_lfsr;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting toward bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 16'hACE1;
    end else if (in_valid) begin
      r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    end
  end

  assign w_noise = ACC_W'(signed'(r_lfsr[NOISE_BITS-1:0]));
`else
  assign w_noise = '0;
`endif

  // Output for the current strobe uses only stored history, never in_data.
  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      w_prod[k] = PROD_W'(r_coef[k]) * PROD_W'(r_dly[k]);
    end
    w_prod[NUM_TAPS] = PROD_W'(r_pole) * PROD_W'(r_y);

    w_acc = '0;
    for (int k = 0; k <= NUM_TAPS; k++) begin
      w_acc = w_acc + ACC_W'(w_prod[k]);
    end

    w_rnd = w_acc + RND;
    w_shf = w_rnd >>> FRAC;
    w_sum = w_shf + w_noise;

    if (w_sum > SAT_MAX) begin
      w_sat = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (w_sum < SAT_MIN) begin
      w_sat = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      w_sat = w_sum[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_dly[k] <= '0;
      end
      r_y         <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_dly[0] <= in_data;
        for (int k = 1; k < NUM_TAPS; k++) begin
          r_dly[k] <= r_dly[k-1];
        end
        r_y        <= w_sat;
        r_out_data <= w_sat;
      end
    end
  end

  // Coefficient writes land at the edge, so a coincident sample sees the old set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_coef[k] <= (k == 0) ? C0_INIT : '0;
      end
      r_pole <= A_INIT;
    end else if (coef_wr) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        if (coef_addr == ADDR_W'(k)) begin
          r_coef[k] <= coef_wdata;
        end
      end
      if (coef_addr == ADDR_W'(NUM_TAPS)) begin
        r_pole <= coef_wdata;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: doc/channel_model.md
CHANNEL_MODEL -- requirements
Module: channel_model

Interface
REQ-001 Parameter DATA_W, default 16, sets the width of the signed two's-complement sample, Q(DATA_W-FRAC).FRAC.
REQ-002 Parameter COEF_W, default 16, sets the width of the signed coefficient, same FRAC.
REQ-003 Parameter FRAC, default 14, gives the number of fractional bits in samples and coefficients.
REQ-004 Parameter NUM_TAPS, default 4, gives the number of feed-forward ISI taps (>=1).
REQ-005 Parameter NOISE_BITS, default 4, gives the width of the signed noise term (used only with CHANNEL_NOISE_EN).
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous and active-low.
REQ-008 in_valid  input  1  sample strobe; one channel sample per high cycle; may be high every cycle.
REQ-009 in_data  input  DATA_W  signed input sample u[n].
REQ-010 coef_wr  input  1  coefficient write strobe.
REQ-011 coef_addr  input  $clog2(NUM_TAPS+1)  0..NUM_TAPS-1 selects tap c_k; NUM_TAPS selects feedback pole a.
REQ-012 coef_wdata  input  COEF_W  signed coefficient value.
REQ-013 out_valid  output  1  one-cycle pulse marking a new out_data.
REQ-014 out_data  output  DATA_W  signed filtered output y[n].

Function
REQ-015 On each in_valid cycle the block SHALL compute y[n] = sum(k=0..NUM_TAPS-1) c_k*u[n-1-k] + a*y[n-1], so the current input affects only the next sample.
REQ-016 The input delay line (NUM_TAPS entries) and y[n-1] SHALL advance only on in_valid cycles; between strobes all state SHALL hold.
REQ-017 out_data and out_valid SHALL be registered, with out_valid high exactly one cycle after each in_valid cycle; out_data SHALL hold its value until the next update.
REQ-018 Products SHALL be full precision, summed in an accumulator of DATA_W+COEF_W+$clog2(NUM_TAPS+1) bits, rounded by adding 2^(FRAC-1), then arithmetically shifted right by FRAC.
REQ-019 The shifted result SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; the saturated value SHALL be both out_data and the fed-back y[n-1].
REQ-020 A coef_wr SHALL update the addressed coefficient at the clock edge; a coef_wr coincident with in_valid SHALL leave that sample computed with the old coefficients.
REQ-021 A coef_wr with coef_addr > NUM_TAPS SHALL be ignored.
REQ-022 Back-to-back in_valid cycles SHALL be processed at full rate with no stall and no dropped samples.

Reset
REQ-023 When rst_n is low: out_data=0, out_valid=0, delay line=0, y[n-1]=0, c_0=round(0.2696*2^FRAC) (4417 at FRAC=14), a=round(0.7304*2^FRAC) (11967), all other c_k=0.
REQ-024 Reset asserted mid-stream SHALL take effect immediately, discard any pending output pulse, and restore the REQ-023 coefficients.

Configuration
REQ-025 With CHANNEL_NOISE_EN defined, the block SHALL include a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) advancing once per in_valid.
REQ-026 With CHANNEL_NOISE_EN defined, the sign-extended low NOISE_BITS bits of the LFSR SHALL be added to the rounded sum before saturation.
REQ-027 Without CHANNEL_NOISE_EN, the block SHALL contain no LFSR logic and the output SHALL be the exact noiseless result of REQ-015 to REQ-019.

Verification
REQ-028 Impulse test, defaults, no noise: in_data=16384 on one in_valid, then 0 on each following in_valid -> out_data sequence 0, 4417, 3226, 2356.
REQ-029 Saturation test: write c_0=16384 and a=16384, then drive a constant 20000 -> out_data 0, 20000, 32767, then holds 32767; drive -20000 -> output saturates to -32768.
REQ-030 Coefficient collision test: coef_wr addr 0 data 0 in the same cycle as in_valid with u=16384 -> that output uses the old c_0; the next sample uses the new c_0 (contributes 0).
REQ-031 Reset mid-stream test: assert rst_n low between in_valid and out_valid -> no out_valid pulse, out_data=0, coefficients back to 4417/11967.
REQ-032 Noise test with CHANNEL_NOISE_EN: all coefficients 0, 20 in_valid strobes -> every out_data is in [-8,7] and matches the LFSR reference model; without the macro every out_data=0.
REQ-033 Invalid address and gap test: coef_wr addr NUM_TAPS+1 -> no coefficient change; idle gaps between in_valid strobes -> output identical to the gapless run.
